// File: rtl/alien_grid_pkg.sv
// rtl/alien_grid_pkg.sv - formation geometry, point values and FSM encoding for alien_grid
package alien_grid_pkg;

  localparam int ROWS       = 5;
  localparam int COLS       = 10;
  localparam int ALIEN_W    = 30;
  localparam int ALIEN_H    = 20;
  localparam int COL_PITCH  = 40;
  localparam int ROW_PITCH  = 30;
  localparam int NUM_ALIENS = ROWS * COLS;

  localparam logic [15:0] PTS_TOP = 16'd30;
  localparam logic [15:0] PTS_MID = 16'd20;
  localparam logic [15:0] PTS_LOW = 16'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCATE  = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_RELOAD  = 2'd3
  } state_e;

  function automatic logic [15:0] row_points(input logic [2:0] row);
    if (row == 3'd0)
      return PTS_TOP;
    else if (row <= 3'd2)
      return PTS_MID;
    else
      return PTS_LOW;
  endfunction

endpackage

// File: rtl/alien_hit_locator.sv
// rtl/alien_hit_locator.sv - maps a signed bullet offset to the struck alien (row, col, valid)
module alien_hit_locator
  import alien_grid_pkg::*;
(
  input  logic signed [10:0] d_row_i,
  input  logic signed [10:0] d_col_i,
  output logic [2:0]         row_o,
  output logic [3:0]         col_o,
  output logic               valid_o
);

  logic row_ok;
  logic col_ok;

  // Each row/column band is tested independently; gaps between sprites fall in no band.
  always_comb begin
    int off_r;
    int off_c;
    off_r  = 0;
    off_c  = 0;
    row_o  = '0;
    col_o  = '0;
    row_ok = 1'b0;
    col_ok = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      off_r = int'(d_row_i) - r * ROW_PITCH;
      if (off_r >= 0 && off_r < ALIEN_H) begin
        row_ok = 1'b1;
        row_o  = 3'(r);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      off_c = int'(d_col_i) - c * COL_PITCH;
      if (off_c >= 0 && off_c < ALIEN_W) begin
        col_ok = 1'b1;
        col_o  = 4'(c);
      end
    end
    valid_o = row_ok && col_ok;
  end

endmodule

// File: rtl/alien_grid.sv
// rtl/alien_grid.sv - alien formation state: bullet hit resolution, scoring and wave reload
module alien_grid
  import alien_grid_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [8:0]  AliensRow,
  input  logic [9:0]  AliensCol,
  input  logic        Game_Over,
  input  logic        Bullet_Valid,
  input  logic [8:0]  Bullet_Row,
  input  logic [9:0]  Bullet_Col,
  output logic        Bullet_Ready,
  output logic        Hit,
  output logic        Miss,
  output logic [5:0]  Hit_Index,
  output logic [49:0] Aliens_Grid,
  output logic        Aliens_Defeated,
  output logic [15:0] Score,
  output logic [3:0]  Wave
);

  state_e             state_q;
  logic [8:0]         brow_q;
  logic [9:0]         bcol_q;
  logic [8:0]         arow_q;
  logic [9:0]         acol_q;
  logic signed [10:0] d_row_q;
  logic signed [10:0] d_col_q;
  logic [49:0]        grid_q;
  logic [15:0]        score_q;
  logic [3:0]         wave_q;
  logic [5:0]         hit_idx_q;
  logic               hit_q;
  logic               miss_q;
  logic               def_q;

  logic [2:0]  loc_row;
  logic [3:0]  loc_col;
  logic        loc_valid;
  logic [5:0]  loc_idx;
  logic        strike;
  logic [49:0] grid_d;
  logic [16:0] score_sum;
  logic [15:0] score_d;

  alien_hit_locator u_locator (
    .d_row_i (d_row_q),
    .d_col_i (d_col_q),
    .row_o   (loc_row),
    .col_o   (loc_col),
    .valid_o (loc_valid)
  );

  assign loc_idx   = 6'(loc_row) * 6'(COLS) + 6'(loc_col);
  assign strike    = loc_valid && grid_q[loc_idx];
  assign grid_d    = grid_q & ~(50'd1 << loc_idx);
  assign score_sum = {1'b0, score_q} + {1'b0, row_points(loc_row)};
  assign score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      brow_q    <= '0;
      bcol_q    <= '0;
      arow_q    <= '0;
      acol_q    <= '0;
      d_row_q   <= '0;
      d_col_q   <= '0;
      grid_q    <= '1;
      score_q   <= '0;
      wave_q    <= '0;
      hit_idx_q <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      def_q     <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      def_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Bullet_Valid && Bullet_Ready) begin
            brow_q  <= Bullet_Row;
            bcol_q  <= Bullet_Col;
            arow_q  <= AliensRow;
            acol_q  <= AliensCol;
            state_q <= ST_LOCATE;
          end
        end
        ST_LOCATE: begin
          d_row_q <= $signed({2'b00, brow_q}) - $signed({2'b00, arow_q});
          d_col_q <= $signed({1'b0, bcol_q}) - $signed({1'b0, acol_q});
          state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (strike) begin
            grid_q    <= grid_d;
            hit_q     <= 1'b1;
            hit_idx_q <= loc_idx;
            score_q   <= score_d;
            if (grid_d == '0) begin
              def_q   <= 1'b1;
              state_q <= ST_RELOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            miss_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_RELOAD: begin
          grid_q  <= '1;
          wave_q  <= wave_q + 4'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Bullet_Ready    = (state_q == ST_IDLE) && !Game_Over;
  assign Hit             = hit_q;
  assign Miss            = miss_q;
  assign Hit_Index       = hit_idx_q;
  assign Aliens_Grid     = grid_q;
  assign Aliens_Defeated = def_q;
  assign Score           = score_q;
  assign Wave            = wave_q;

endmodule

// File: tb/tb_alien_grid.sv
// tb/tb_alien_grid.sv - randomized and directed self-checking bench for alien_grid
module tb_alien_grid;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [8:0]  AliensRow;
  logic [9:0]  AliensCol;
  logic        Game_Over;
  logic        Bullet_Valid;
  logic [8:0]  Bullet_Row;
  logic [9:0]  Bullet_Col;
  logic        Bullet_Ready;
  logic        Hit;
  logic        Miss;
  logic [5:0]  Hit_Index;
  logic [49:0] Aliens_Grid;
  logic        Aliens_Defeated;
  logic [15:0] Score;
  logic [3:0]  Wave;

  alien_grid dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .AliensRow       (AliensRow),
    .AliensCol       (AliensCol),
    .Game_Over       (Game_Over),
    .Bullet_Valid    (Bullet_Valid),
    .Bullet_Row      (Bullet_Row),
    .Bullet_Col      (Bullet_Col),
    .Bullet_Ready    (Bullet_Ready),
    .Hit             (Hit),
    .Miss            (Miss),
    .Hit_Index       (Hit_Index),
    .Aliens_Grid     (Aliens_Grid),
    .Aliens_Defeated (Aliens_Defeated),
    .Score           (Score),
    .Wave            (Wave)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a shot is accepted, then resolved two edges later by plain
  // division of the offset into sprite pitch / remainder.
  logic [49:0] m_grid;
  int          m_score, m_wave, m_idx, m_cnt;
  bit          m_hit, m_miss, m_def, m_reload;
  int          c_br, c_bc, c_ar, c_ac;

  always @(posedge Clk or negedge Reset_n) begin : model
    int dr, dc, r, c, idx, pts;
    bit struck;
    if (!Reset_n) begin
      m_grid <= '1; m_score <= 0; m_wave <= 0; m_idx <= 0; m_cnt <= 0;
      m_hit <= 0; m_miss <= 0; m_def <= 0; m_reload <= 0;
      c_br <= 0; c_bc <= 0; c_ar <= 0; c_ac <= 0;
    end else begin
      m_hit <= 0; m_miss <= 0; m_def <= 0;
      if (m_reload) begin
        m_grid   <= '1;
        m_wave   <= (m_wave + 1) % 16;
        m_reload <= 0;
      end else if (m_cnt == 2) begin
        m_cnt <= 1;
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        dr     = c_br - c_ar;
        dc     = c_bc - c_ac;
        struck = dr >= 0 && dc >= 0 && dr / 30 < 5 && dr % 30 < 20 && dc / 40 < 10 && dc % 40 < 30;
        idx    = struck ? (dr / 30) * 10 + dc / 40 : 0;
        if (struck && m_grid[idx]) begin
          r   = dr / 30;
          pts = (r == 0) ? 30 : ((r < 3) ? 20 : 10);
          m_grid  <= m_grid & ~(50'd1 << idx);
          m_hit   <= 1;
          m_idx   <= idx;
          m_score <= (m_score + pts > 65535) ? 65535 : m_score + pts;
          if ((m_grid & ~(50'd1 << idx)) == '0) begin
            m_def    <= 1;
            m_reload <= 1;
          end
        end else begin
          m_miss <= 1;
        end
      end else if (Bullet_Valid && !Game_Over) begin
        c_br <= Bullet_Row; c_bc <= Bullet_Col;
        c_ar <= AliensRow;  c_ac <= AliensCol;
        m_cnt <= 2;
      end
    end
  end

  always @(negedge Clk) begin
    chk("ready", Bullet_Ready, (m_cnt == 0 && !m_reload && !Game_Over));
    chk("hit", Hit, m_hit);
    chk("miss", Miss, m_miss);
    chk("defeated", Aliens_Defeated, m_def);
    chk("hit_index", Hit_Index, 64'(m_idx));
    chk("grid", Aliens_Grid, m_grid);
    chk("score", Score, 64'(m_score));
    chk("wave", Wave, 64'(m_wave));
  end

  task automatic shoot(input int br, input int bc);
    Bullet_Row = 9'(br); Bullet_Col = 10'(bc); Bullet_Valid = 1'b1;
    @(posedge Clk); #1 Bullet_Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic shoot_lat(input int br, input int bc, input bit eh, input bit em, input bit ed);
    Bullet_Row = 9'(br); Bullet_Col = 10'(bc); Bullet_Valid = 1'b1;
    @(posedge Clk); #1 Bullet_Valid = 1'b0;
    @(negedge Clk); chk("lat_e1", {Hit, Miss}, 2'b00);
    @(negedge Clk); chk("lat_e2", {Hit, Miss}, 2'b00);
    @(negedge Clk); chk("lat_e3", {Hit, Miss, Aliens_Defeated}, {eh, em, ed});
    @(negedge Clk); chk("lat_e4", {Hit, Miss}, 2'b00);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    AliensRow = '0; AliensCol = 10'd10; Game_Over = 1'b0;
    Bullet_Valid = 1'b0; Bullet_Row = '0; Bullet_Col = '0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_grid", Aliens_Grid, 50'h3FFFFFFFFFFFF);
    chk("rst_score", Score, 0);
    chk("rst_wave", Wave, 0);
    chk("rst_ready", Bullet_Ready, 1);
    @(posedge Clk); #1;

    shoot_lat(5, 15, 1, 0, 0);
    chk("k0_index", Hit_Index, 0);
    chk("k0_grid", Aliens_Grid, 50'h3FFFFFFFFFFFE);
    chk("k0_score", Score, 30);

    shoot_lat(125, 375, 1, 0, 0);
    chk("k49_index", Hit_Index, 49);
    chk("k49_score", Score, 40);
    shoot_lat(125, 375, 0, 1, 0);
    chk("rep_score", Score, 40);
    chk("rep_index", Hit_Index, 49);

    shoot_lat(5, 45, 0, 1, 0);
    chk("gap_grid", Aliens_Grid, 50'h1FFFFFFFFFFFE);

    Bullet_Row = 9'd35; Bullet_Col = 10'd55; Bullet_Valid = 1'b1;
    @(posedge Clk); #1 Bullet_Valid = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (4) @(negedge Clk) chk("rst_mid_pulse", {Hit, Miss, Aliens_Defeated}, 3'b000);
    chk("rst_mid_grid", Aliens_Grid, 50'h3FFFFFFFFFFFF);
    chk("rst_mid_score", Score, 0);
    @(posedge Clk); #1;

    for (int i = 0; i < 50; i++)
      if (i != 22) shoot((i / 10) * 30 + 5, 10 + (i % 10) * 40 + 5);
    chk("only22_grid", Aliens_Grid, 50'h400000);
    shoot_lat(65, 95, 1, 0, 1);
    chk("last_index", Hit_Index, 22);
    chk("reload_grid", Aliens_Grid, 50'h3FFFFFFFFFFFF);
    chk("reload_wave", Wave, 1);
    chk("wave_score", Score, 900);

    Game_Over = 1'b1; Bullet_Valid = 1'b1; Bullet_Row = 9'd5; Bullet_Col = 10'd15;
    repeat (3) @(posedge Clk);
    #1 chk("go_ready", Bullet_Ready, 0);
    repeat (3) @(posedge Clk);
    #1 chk("go_grid", Aliens_Grid, 50'h3FFFFFFFFFFFF);
    Game_Over = 1'b0; Bullet_Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      AliensRow    = 9'($urandom_range(0, 200));
      AliensCol    = 10'($urandom_range(0, 400));
      Bullet_Valid = ($urandom_range(0, 1) == 1);
      Game_Over    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) begin
        Bullet_Row = AliensRow + 9'($urandom_range(0, 150));
        Bullet_Col = AliensCol + 10'($urandom_range(0, 400));
      end else begin
        Bullet_Row = 9'($urandom_range(0, 511));
        Bullet_Col = 10'($urandom_range(0, 1023));
      end
      @(posedge Clk); #1;
    end
    Bullet_Valid = 1'b0; Game_Over = 1'b0;
    AliensRow = '0; AliensCol = 10'd10;
    repeat (4) @(posedge Clk);
    #1;

    do_reset();
    for (int w = 0; w < 80; w++)
      for (int i = 0; i < 50; i++)
        shoot((i / 10) * 30 + 5, 10 + (i % 10) * 40 + 5);
    chk("sat_score", Score, 16'hFFFF);
    chk("sat_wave", Wave, 0);
    chk("sat_grid", Aliens_Grid, 50'h3FFFFFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
